traffic_input_conditioner: RTL
==============================

# traffic_input_conditioner

Front-end stage for the traffic-light controller. It conditions the raw pedestrian push-button and the inductive-loop car sensor into the clean, single-clock-domain `pedestrian_button` and `car_sensor` inputs that the controller consumes:
- 2-flop synchronisation and debounce on both inputs.
- A latched pedestrian request that holds until the controller serves it with RED.
- A hold-extended car-presence signal.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised input must differ from its stable value before the stable value flips; legal range 1..255.
- `CAR_HOLD_CYCLES`, 8: cycles `car_present` stays high after the debounced car sensor falls; 0 means no extension.
- `BLINK_CYCLES`, 5: half-period of the wait-lamp blink; only used when `PED_WAIT_BLINK_EN` is defined.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `ped_button_raw`  in  1  asynchronous push-button, active-high
- `car_sensor_raw`  in  1  asynchronous loop detector, active-high
- `lights_in`  in  3  one-hot lamp state fed back from the controller (RED=001, YELLOW=010, GREEN=100)
- `ped_request`  out  1  latched pedestrian demand; drives the controller's `pedestrian_button`
- `car_present`  out  1  filtered car presence; drives the controller's `car_sensor`
- `ped_wait_lamp`  out  1  "WAIT" indicator at the crossing

## Operation
- **Synchroniser.** Each raw input passes through its own 2-flop synchroniser; both flops reset to 0.
- **Debouncer (per input).** States and transitions:
  - STABLE_LO → PEND_HI when sync=1.
  - PEND_HI → STABLE_LO when sync=0; the counter clears.
  - PEND_HI → STABLE_HI when the counter reaches `DEBOUNCE_CYCLES`.
  - STABLE_HI, PEND_LO: mirror images of the above.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - Counter saturates and never wraps.
  - Any glitch shorter than `DEBOUNCE_CYCLES` is fully rejected.
- **Pedestrian latch.**
  - Set on a rising edge of the debounced button.
  - Cleared on the first cycle in which `lights_in`==RED while the previous cycle's `lights_in`!=RED. This needs a 1-cycle registered copy of `lights_in`, reset value GREEN.
  - Set and clear in the same cycle: set wins, and the request stays high.
  - A held button does not re-arm; a new debounced rising edge is required.
- **Car hold.**
  - Hold counter loads `CAR_HOLD_CYCLES` on the falling edge of the debounced car signal and decrements to 0.
  - `car_present` (registered) = debounced car OR hold counter != 0.
  - A car returning during the hold reasserts the debounced value; the counter reloads on the next fall.
- **Invalid `lights_in`.** Any value that is not one-hot is treated as not-RED.

## Timing
- Reset values: `ped_request`=0, `car_present`=0, `ped_wait_lamp`=0, debouncers STABLE_LO, all counters 0.
- Raw edge to debounced flip: 2 + `DEBOUNCE_CYCLES` rising edges.
- Raw edge to `ped_request`/`car_present` change: 3 + `DEBOUNCE_CYCLES` edges (7 at defaults).
- `car_present` falls exactly `CAR_HOLD_CYCLES` cycles after the debounced car signal falls, i.e. 3 + `DEBOUNCE_CYCLES` + `CAR_HOLD_CYCLES` edges after the raw fall.
- `ped_request` clears on the edge after the first RED cycle (1-cycle latency).
- Reset mid-debounce or mid-hold aborts immediately with no residual request. After reset release, an input that is already high still needs the full latency.

## Configuration
- `PED_WAIT_BLINK_EN` defined:
  - While `ped_request`=1, `ped_wait_lamp` toggles every `BLINK_CYCLES` cycles, starting high on the cycle `ped_request` rises.
  - It is forced 0 on the cycle `ped_request` falls.
  - The blink counter resets to 0 on every request set.
- `PED_WAIT_BLINK_EN` undefined:
  - `ped_wait_lamp` = `ped_request`, steady.
  - No blink counter is synthesised.

## Structure
- Shared package `traffic_pkg`:
  - Lamp encodings RED/YELLOW/GREEN (3-bit one-hot).
  - Debouncer state enum STABLE_LO/PEND_HI/STABLE_HI/PEND_LO.
- Sub-module `input_debouncer`:
  - Contains the synchroniser, state machine and counter.
  - Parameterised by `DEBOUNCE_CYCLES`; exposes `stable`, `rise`, `fall`.
  - Instantiated twice, once per input.

## Test plan
- Button pulse 3 cycles, defaults → `ped_request` never rises; pulse of 10 cycles → `ped_request`=1 at edge 7 after raw rise, `ped_wait_lamp`=1.
- `ped_request` set, `lights_in` GREEN→YELLOW→RED → `ped_request`=0 on the edge after the first RED cycle. RED held for 10 more cycles → stays 0.
- Debounced button rises in the same cycle as the RED transition → `ped_request` remains 1.
- Car raw high 20 cycles then low → `car_present` high from edge 7 after rise until 15 edges after fall. Car returns 3 cycles into the hold → no gap in `car_present`.
- Reset asserted mid-PEND_HI and mid-hold → all outputs 0 immediately. Raw car still high after release → `car_present`=1 at edge 7.
- `PED_WAIT_BLINK_EN` defined, `BLINK_CYCLES`=5, request held 20 cycles → lamp pattern 5 high / 5 low / 5 high / 5 low, 0 after clear.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light front end: one-hot lamp codes and debouncer states.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } deb_state_e;

endpackage

// File: rtl/input_debouncer.sv
// 2-flop synchroniser plus counting debouncer; stable flips only after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module input_debouncer
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_d;
  logic          sync;

  assign sync = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stable  <= stable_d;
      rise    <= stable_d & ~stable;
      fall    <= ~stable_d & stable;
    end
  end

  // The first disagreeing sample counts as 1, so a 1-cycle debounce flips straight from STABLE_*.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (sync) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CW'(1);
          end
        end
      end
      PEND_HI: begin
        if (!sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX - CW'(1)) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CW'(1);
          end
        end
      end
      PEND_LO: begin
        if (sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX - CW'(1)) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    stable_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
  end

endmodule

// File: rtl/traffic_input_conditioner.sv
// Conditions raw pedestrian button and car loop into controller inputs.
// Optional blinking WAIT lamp when PED_WAIT_BLINK_EN is defined.
module traffic_input_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CAR_HOLD_CYCLES = 8,
  parameter int unsigned BLINK_CYCLES    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_button_raw,
  input  logic       car_sensor_raw,
  input  logic [2:0] lights_in,
  output logic       ped_request,
  output logic       car_present,
  output logic       ped_wait_lamp
);

  localparam int unsigned HW = (CAR_HOLD_CYCLES > 0) ? $clog2(CAR_HOLD_CYCLES + 1) : 1;

  logic          ped_stable, ped_rise, ped_fall;
  logic          car_stable, car_rise, car_fall;
  logic [2:0]    lights_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          red_edge;
  logic          ped_d;
  logic          unused_deb;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_deb (
    .clk    (clk),
    .reset  (reset),
    .raw    (ped_button_raw),
    .stable (ped_stable),
    .rise   (ped_rise),
    .fall   (ped_fall)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car_deb (
    .clk    (clk),
    .reset  (reset),
    .raw    (car_sensor_raw),
    .stable (car_stable),
    .rise   (car_rise),
    .fall   (car_fall)
  );

  assign unused_deb = ^{ped_stable, ped_fall, car_rise};

  // Non-one-hot lamp codes never equal RED, so they count as not-RED.
  always_comb begin
    red_edge = (lights_in == LAMP_RED) && (lights_q != LAMP_RED);
    ped_d    = ped_rise | (ped_request & ~red_edge);
    hold_d   = hold_q;
    if (car_fall) begin
      hold_d = HW'(CAR_HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lights_q    <= LAMP_GREEN;
      hold_q      <= '0;
      ped_request <= 1'b0;
      car_present <= 1'b0;
    end else begin
      lights_q    <= lights_in;
      hold_q      <= hold_d;
      ped_request <= ped_d;
      car_present <= car_stable | (hold_d != '0);
    end
  end

`ifdef PED_WAIT_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  logic [BW-1:0] blink_q;

  // Lamp starts high with each request set and toggles every BLINK_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q       <= '0;
      ped_wait_lamp <= 1'b0;
    end else if (!ped_d) begin
      blink_q       <= '0;
      ped_wait_lamp <= 1'b0;
    end else if (ped_rise) begin
      blink_q       <= '0;
      ped_wait_lamp <= 1'b1;
    end else if (blink_q >= BW'(BLINK_CYCLES - 1)) begin
      blink_q       <= '0;
      ped_wait_lamp <= ~ped_wait_lamp;
    end else begin
      blink_q <= blink_q + BW'(1);
    end
  end
`else
  localparam int unsigned unused_blink_cycles = BLINK_CYCLES;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_wait_lamp <= 1'b0;
    end else begin
      ped_wait_lamp <= ped_d;
    end
  end
`endif

endmodule
